// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame sender: FSM encoding, default
// timing constants and a width helper for counters.
package ws2812_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    localparam int DEF_MAX_LEDS  = 64;
    localparam int DEF_COLOR_W   = 24;
    localparam int DEF_T0H_CYC   = 40;
    localparam int DEF_T1H_CYC   = 80;
    localparam int DEF_BIT_CYC   = 125;
    localparam int DEF_RESET_CYC = 30000;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_frame_sender_if.sv
// Pixel stream into the frame sender. A word transfers on a rising clk edge where
// pix_valid and pix_ready are both 1; the source holds pix_data while pix_valid is unaccepted.
interface ws2812_frame_sender_if #(
    parameter int COLOR_W = ws2812_pkg::DEF_COLOR_W
) ();
    logic [COLOR_W-1:0] pix_data;
    logic               pix_valid;
    logic               pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/ws2812_bit_encoder.sv
// One NZR bit per load pulse: flags the last high cycle (T1H/T0H) and the last
// cycle of the BIT_CYC period; a load on that last cycle starts the next bit seamlessly.
module ws2812_bit_encoder import ws2812_pkg::*; #(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic bit_val,
    output logic high_done,
    output logic bit_done
);
    localparam int CW = idx_w(BIT_CYC);
    localparam logic [CW-1:0] T0_LAST  = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] T1_LAST  = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);

    logic [CW-1:0] cnt;
    logic          cur_bit;
    logic          active;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            cur_bit <= 1'b0;
            active  <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            cur_bit <= bit_val;
            active  <= 1'b1;
        end else if (active) begin
            if (cnt == BIT_LAST) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        high_done = active && (cnt == (cur_bit ? T1_LAST : T0_LAST));
        bit_done  = active && (cnt == BIT_LAST);
    end

endmodule

// File: rtl/ws2812_frame_sender.sv
// WS2812 frame sender: streams num_leds pixels from a valid/ready source as NZR
// bits, with a one-word prefetch buffer so pixel boundaries need no gap cycle.
module ws2812_frame_sender import ws2812_pkg::*; #(
    parameter int MAX_LEDS  = DEF_MAX_LEDS,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int BIT_CYC   = DEF_BIT_CYC,
    parameter int RESET_CYC = DEF_RESET_CYC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(MAX_LEDS+1)-1:0] num_leds,
    ws2812_frame_sender_if.slave          pix,
    output logic                          dataOut,
    output logic                          Ready2Go,
    output logic                          underrun,
    output logic [idx_w(MAX_LEDS)-1:0]    led_index,
    output state_t                        state_dbg
);
    localparam int CNT_W = $clog2(MAX_LEDS + 1);
    localparam int IDX_W = idx_w(MAX_LEDS);
    localparam int BIT_W = idx_w(COLOR_W);
    localparam int LAT_W = idx_w(RESET_CYC);
    localparam logic [CNT_W-1:0] MAX_N    = CNT_W'(MAX_LEDS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(COLOR_W - 1);
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(RESET_CYC - 1);

    if (!(T0H_CYC >= 2 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC &&
          MAX_LEDS >= 1 && COLOR_W >= 2 && RESET_CYC >= 1)) begin : g_param_check
        $error("ws2812_frame_sender: need 2 <= T0H_CYC < T1H_CYC < BIT_CYC, MAX_LEDS >= 1, COLOR_W >= 2");
    end

    state_t             state, state_n;
    logic [CNT_W-1:0]   n_leds;
    logic [CNT_W-1:0]   fetch_cnt;
    logic [COLOR_W-1:0] buf_q;
    logic               buf_full;
    logic [COLOR_W-1:0] shreg;
    logic [BIT_W-1:0]   bit_idx;
    logic [LAT_W-1:0]   latch_cnt;

    logic [CNT_W-1:0]   n_clamped;
    logic               led_last;
    logic               pix_xfer;
    logic               take_buf, shift_bit, inc_led, underrun_n;
    logic               enc_load, enc_bit;
    logic               high_done, bit_done;

    assign n_clamped     = (num_leds > MAX_N) ? MAX_N : num_leds;
    assign led_last      = (CNT_W'(led_index) + CNT_W'(1)) == n_leds;
    assign pix.pix_ready = (state == S_FETCH || state == S_HIGH || state == S_LOW) &&
                           !buf_full && (fetch_cnt < n_leds);
    assign pix_xfer      = pix.pix_valid && pix.pix_ready;
    assign dataOut       = (state == S_HIGH);
    assign Ready2Go      = (state == S_IDLE);
    assign state_dbg     = state;

    ws2812_bit_encoder #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_encoder (
        .clk       (clk),
        .reset     (reset),
        .load      (enc_load),
        .bit_val   (enc_bit),
        .high_done (high_done),
        .bit_done  (bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Each bit is launched on the last cycle of the previous one, keeping periods contiguous.
    always_comb begin
        state_n    = state;
        take_buf   = 1'b0;
        shift_bit  = 1'b0;
        inc_led    = 1'b0;
        underrun_n = 1'b0;
        enc_load   = 1'b0;
        enc_bit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (n_clamped == '0) ? S_LATCH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (buf_full) begin
                    take_buf = 1'b1;
                    enc_load = 1'b1;
                    enc_bit  = buf_q[COLOR_W-1];
                    state_n  = S_HIGH;
                end
            end
            S_HIGH: begin
                if (high_done) begin
                    state_n = S_LOW;
                end
            end
            S_LOW: begin
                if (bit_done) begin
                    if (bit_idx != LAST_BIT) begin
                        shift_bit = 1'b1;
                        enc_load  = 1'b1;
                        enc_bit   = shreg[COLOR_W-2];
                        state_n   = S_HIGH;
                    end else if (led_last) begin
                        state_n = S_LATCH;
                    end else if (buf_full) begin
                        take_buf = 1'b1;
                        inc_led  = 1'b1;
                        enc_load = 1'b1;
                        enc_bit  = buf_q[COLOR_W-1];
                        state_n  = S_HIGH;
                    end else begin
                        underrun_n = 1'b1;
                        state_n    = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                if (latch_cnt == LAST_LAT) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_leds    <= '0;
            fetch_cnt <= '0;
            buf_q     <= '0;
            buf_full  <= 1'b0;
            shreg     <= '0;
            bit_idx   <= '0;
            led_index <= '0;
            latch_cnt <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= underrun_n;
            if (state == S_IDLE && start) begin
                n_leds    <= n_clamped;
                fetch_cnt <= '0;
                led_index <= '0;
            end
            if (take_buf) begin
                buf_full <= 1'b0;
            end
            if (pix_xfer) begin
                buf_q     <= pix.pix_data;
                buf_full  <= 1'b1;
                fetch_cnt <= fetch_cnt + 1'b1;
            end
            if (take_buf) begin
                shreg   <= buf_q;
                bit_idx <= '0;
            end else if (shift_bit) begin
                shreg   <= shreg << 1;
                bit_idx <= bit_idx + 1'b1;
            end
            if (inc_led) begin
                led_index <= led_index + 1'b1;
            end
            latch_cnt <= (state == S_LATCH) ? latch_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_sender.sv
// Self-checking bench for ws2812_frame_sender: bit high-times and LED indices are
// queued when a pixel is accepted and checked as the NZR waveform appears.
module tb_ws2812_frame_sender;
    import ws2812_pkg::*;

    localparam int MAX_LEDS = 4;
    localparam int COLOR_W  = 24;
    localparam int T0H      = 4;
    localparam int T1H      = 8;
    localparam int BITC     = 12;
    localparam int RST      = 50;
    localparam int NW       = $clog2(MAX_LEDS + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NW-1:0] num_leds;
    logic          dataOut;
    logic          Ready2Go;
    logic          underrun;
    logic [1:0]    led_index;
    state_t        state_dbg;

    ws2812_frame_sender_if #(.COLOR_W(COLOR_W)) pix ();

    ws2812_frame_sender #(
        .MAX_LEDS  (MAX_LEDS),
        .COLOR_W   (COLOR_W),
        .T0H_CYC   (T0H),
        .T1H_CYC   (T1H),
        .BIT_CYC   (BITC),
        .RESET_CYC (RST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_leds  (num_leds),
        .pix       (pix),
        .dataOut   (dataOut),
        .Ready2Go  (Ready2Go),
        .underrun  (underrun),
        .led_index (led_index),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]         exp_q[$];
    logic [1:0]         idx_q[$];
    logic [COLOR_W-1:0] src_q[$];

    int   px_idx = 0;
    int   xfer_cnt = 0;
    int   cyc = 0;
    int   last_rise = -1000;
    int   rise_cnt = 0;
    int   hi_len = 0;
    int   under_cnt = 0;
    int   under_cyc = 0;
    int   rdy_rise_cyc = 0;
    int   low_len = 0;
    int   last_low_len = 0;
    logic prev_out = 1'b0;
    logic prev_rdy = 1'b1;
    bit   mon_mute = 1'b0;
    logic [7:0] exp_hi;
    logic [1:0] exp_idx;

    // Pixel source and waveform scoreboard share one negedge process.
    always @(negedge clk) begin
        cyc++;
        if (src_q.size() > 0) begin
            pix.pix_valid = 1'b1;
            pix.pix_data  = src_q[0];
        end else begin
            pix.pix_valid = 1'b0;
            pix.pix_data  = COLOR_W'($urandom);
        end
        if (pix.pix_valid && pix.pix_ready) begin
            for (int b = COLOR_W - 1; b >= 0; b--) begin
                exp_q.push_back(src_q[0][b] ? 8'(T1H) : 8'(T0H));
                idx_q.push_back(2'(px_idx));
            end
            void'(src_q.pop_front());
            px_idx++;
            xfer_cnt++;
        end

        if (mon_mute) begin
            hi_len    = 0;
            last_rise = -1000;
        end else begin
            if (dataOut && !prev_out) begin
                rise_cnt++;
                if (cyc - last_rise <= RST) begin
                    n_cmp++;
                    if (cyc - last_rise !== BITC) begin
                        n_err++;
                        $display("FAIL bit_period: got %0d cycles, want %0d (cycle %0d)", cyc - last_rise, BITC, cyc);
                    end
                end
                last_rise = cyc;
                hi_len    = 1;
                n_cmp++;
                if (idx_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_bit: high pulse at cycle %0d, want none", cyc);
                end else begin
                    exp_idx = idx_q.pop_front();
                    if (led_index !== exp_idx) begin
                        n_err++;
                        $display("FAIL led_index: got %0d, want %0d (cycle %0d)", led_index, exp_idx, cyc);
                    end
                end
            end else if (dataOut) begin
                hi_len++;
            end
            if (!dataOut && prev_out) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL high_time: got pulse of %0d cycles, want no pulse", hi_len);
                end else begin
                    exp_hi = exp_q.pop_front();
                    if (hi_len !== int'(exp_hi)) begin
                        n_err++;
                        $display("FAIL high_time: got %0d cycles, want %0d (cycle %0d)", hi_len, exp_hi, cyc);
                    end
                end
            end
        end
        prev_out = dataOut;

        if (underrun === 1'b1) begin
            under_cnt++;
            under_cyc = cyc;
        end
        if (Ready2Go && !prev_rdy) begin
            rdy_rise_cyc = cyc;
            last_low_len = low_len;
        end
        low_len  = Ready2Go ? 0 : low_len + 1;
        prev_rdy = Ready2Go;
    end

    task automatic start_frame(input int n);
        @(negedge clk); #1;
        px_idx   = 0;
        num_leds = NW'(n);
        start    = 1'b1;
        @(negedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!Ready2Go && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (!Ready2Go) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: Ready2Go got %b after %0d cycles, want 1", name, Ready2Go, n);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (Ready2Go !== 1'b1) begin n_err++; $display("FAIL reset_ready2go: got %b, want 1", Ready2Go); end
        n_cmp++;
        if (dataOut !== 1'b0) begin n_err++; $display("FAIL reset_dataout: got %b, want 0", dataOut); end
        n_cmp++;
        if (pix.pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_pix_ready: got %b, want 0", pix.pix_ready); end
        n_cmp++;
        if (underrun !== 1'b0 || led_index !== 2'd0) begin
            n_err++;
            $display("FAIL reset_underrun_idx: got %b/%0d, want 0/0", underrun, led_index);
        end
    endtask

    task automatic test_single();
        int r0, u0;
        r0 = rise_cnt; u0 = under_cnt;
        src_q.push_back(24'hAA0000);
        start_frame(1);
        wait_idle("single");
        n_cmp++;
        if (rise_cnt - r0 !== 24) begin n_err++; $display("FAIL single_bits: got %0d, want 24", rise_cnt - r0); end
        n_cmp++;
        if (exp_q.size() !== 0) begin n_err++; $display("FAIL single_drain: got %0d bits left, want 0", exp_q.size()); end
        n_cmp++;
        if (rdy_rise_cyc - last_rise !== BITC + RST) begin
            n_err++;
            $display("FAIL single_latch: got %0d cycles last rise to idle, want %0d", rdy_rise_cyc - last_rise, BITC + RST);
        end
        n_cmp++;
        if (under_cnt - u0 !== 0) begin n_err++; $display("FAIL single_underrun: got %0d, want 0", under_cnt - u0); end
    endtask

    task automatic test_three();
        int r0, u0, x0;
        r0 = rise_cnt; u0 = under_cnt; x0 = xfer_cnt;
        for (int i = 0; i < 4; i++) src_q.push_back(COLOR_W'($urandom));
        start_frame(3);
        wait_idle("three");
        n_cmp++;
        if (rise_cnt - r0 !== 72) begin n_err++; $display("FAIL three_bits: got %0d, want 72", rise_cnt - r0); end
        n_cmp++;
        if (xfer_cnt - x0 !== 3) begin n_err++; $display("FAIL three_xfers: got %0d, want 3", xfer_cnt - x0); end
        n_cmp++;
        if (under_cnt - u0 !== 0) begin n_err++; $display("FAIL three_underrun: got %0d, want 0", under_cnt - u0); end
        n_cmp++;
        if (rdy_rise_cyc - last_rise !== BITC + RST) begin
            n_err++;
            $display("FAIL three_latch: got %0d, want %0d", rdy_rise_cyc - last_rise, BITC + RST);
        end
        src_q.delete();
    endtask

    task automatic test_start_ignored();
        int r0, x0;
        r0 = rise_cnt; x0 = xfer_cnt;
        for (int i = 0; i < 2; i++) src_q.push_back(COLOR_W'($urandom));
        start_frame(2);
        repeat ($urandom_range(20, 200)) @(negedge clk);
        #1;
        num_leds = NW'(1);
        start    = 1'b1;
        @(negedge clk); #1;
        start    = 1'b0;
        wait_idle("busy_start");
        n_cmp++;
        if (rise_cnt - r0 !== 48) begin n_err++; $display("FAIL busy_start_bits: got %0d, want 48", rise_cnt - r0); end
        n_cmp++;
        if (xfer_cnt - x0 !== 2) begin n_err++; $display("FAIL busy_start_xfers: got %0d, want 2", xfer_cnt - x0); end
    endtask

    task automatic test_underrun();
        int r0, u0, x0;
        r0 = rise_cnt; u0 = under_cnt; x0 = xfer_cnt;
        src_q.push_back(COLOR_W'($urandom));
        start_frame(2);
        wait_idle("underrun");
        n_cmp++;
        if (under_cnt - u0 !== 1) begin n_err++; $display("FAIL underrun_count: got %0d, want 1", under_cnt - u0); end
        n_cmp++;
        if (under_cyc - last_rise !== BITC) begin
            n_err++;
            $display("FAIL underrun_when: got %0d cycles after last rise, want %0d", under_cyc - last_rise, BITC);
        end
        n_cmp++;
        if (rdy_rise_cyc - under_cyc !== RST) begin
            n_err++;
            $display("FAIL underrun_latch: got %0d, want %0d", rdy_rise_cyc - under_cyc, RST);
        end
        n_cmp++;
        if (rise_cnt - r0 !== 24 || xfer_cnt - x0 !== 1) begin
            n_err++;
            $display("FAIL underrun_bits: got %0d bits/%0d xfers, want 24/1", rise_cnt - r0, xfer_cnt - x0);
        end
    endtask

    task automatic test_zero();
        int r0, x0;
        r0 = rise_cnt; x0 = xfer_cnt;
        src_q.push_back(COLOR_W'($urandom));
        start_frame(0);
        wait_idle("zero");
        n_cmp++;
        if (rise_cnt - r0 !== 0 || xfer_cnt - x0 !== 0) begin
            n_err++;
            $display("FAIL zero_activity: got %0d bits/%0d xfers, want 0/0", rise_cnt - r0, xfer_cnt - x0);
        end
        n_cmp++;
        if (last_low_len !== RST) begin n_err++; $display("FAIL zero_latch: got %0d, want %0d", last_low_len, RST); end
        src_q.delete();
    endtask

    task automatic test_clamp();
        int r0, u0, x0;
        r0 = rise_cnt; u0 = under_cnt; x0 = xfer_cnt;
        for (int i = 0; i < 6; i++) src_q.push_back(COLOR_W'($urandom));
        start_frame(7);
        wait_idle("clamp");
        n_cmp++;
        if (rise_cnt - r0 !== 96) begin n_err++; $display("FAIL clamp_bits: got %0d, want 96", rise_cnt - r0); end
        n_cmp++;
        if (xfer_cnt - x0 !== 4 || under_cnt - u0 !== 0) begin
            n_err++;
            $display("FAIL clamp_xfers: got %0d xfers/%0d underruns, want 4/0", xfer_cnt - x0, under_cnt - u0);
        end
        src_q.delete();
    endtask

    task automatic test_reset_mid();
        int n, r0;
        for (int i = 0; i < 2; i++) src_q.push_back(COLOR_W'($urandom));
        start_frame(2);
        n = 0;
        while (!dataOut && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        @(negedge clk); #1;
        n_cmp++;
        if (dataOut !== 1'b1) begin n_err++; $display("FAIL midreset_in_high: got %b, want 1", dataOut); end
        mon_mute = 1'b1;
        reset    = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (dataOut !== 1'b0 || Ready2Go !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_outputs: got dataOut=%b Ready2Go=%b, want 0/1", dataOut, Ready2Go);
        end
        n_cmp++;
        if (pix.pix_ready !== 1'b0 || underrun !== 1'b0 || led_index !== 2'd0 || state_dbg !== S_IDLE) begin
            n_err++;
            $display("FAIL midreset_state: got ready=%b under=%b idx=%0d state=%0d, want 0/0/0/%0d",
                     pix.pix_ready, underrun, led_index, state_dbg, S_IDLE);
        end
        reset = 1'b0;
        exp_q.delete();
        idx_q.delete();
        src_q.delete();
        @(negedge clk); #1;
        mon_mute = 1'b0;
        r0 = rise_cnt;
        src_q.push_back(COLOR_W'($urandom));
        start_frame(1);
        wait_idle("after_reset");
        n_cmp++;
        if (rise_cnt - r0 !== 24 || exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL after_reset_frame: got %0d bits/%0d left, want 24/0", rise_cnt - r0, exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        num_leds = '0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk); #1;
        test_reset();
        test_single();
        test_three();
        test_start_ignored();
        test_underrun();
        test_zero();
        test_clamp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
